// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit teaching CPU: widths, ALU op codes, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DW = 8;   // data width: R0, R1, X, DR, TR, IR, memory data
    localparam int AW = 16;  // address / internal bus width, always 2*DW

    localparam logic [3:0] ALU_CLR  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_INC  = 4'b0011;
    localparam logic [3:0] ALU_DEC  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SHL  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    // Zero-extend a data byte onto the address-wide bus.
    function automatic logic [AW-1:0] zext(input logic [DW-1:0] v);
        return {{(AW-DW){1'b0}}, v};
    endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Control-unit / memory <-> datapath signal bundle.
// Latency: n/a (wires only). Backpressure: none; strobes are sampled every edge.
// master = control unit + memory side, slave = datapath.
interface cpu_datapath_if;
    import cpu_pkg::*;

    // register / memory strobes
    logic read, write, arload, arinc, pcinc, pcload;
    logic drload, trload, irload, r1load, r0load, xload, zload;
    // bus-source / memory-sink enables
    logic pcbus, drhbus, drlbus, trbus, r1bus, r0bus, membus, busmem;
    logic [3:0]    alus;
    // memory port and observation outputs
    logic [DW-1:0] mem_din;
    logic [AW-1:0] addr;
    logic [DW-1:0] mem_dout;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] ir_out;
    logic          z_out;
    logic [DW-1:0] r0_out;
    logic          bus_err;

    modport master (
        output read, write, arload, arinc, pcinc, pcload,
        output drload, trload, irload, r1load, r0load, xload, zload,
        output pcbus, drhbus, drlbus, trbus, r1bus, r0bus, membus, busmem,
        output alus, mem_din,
        input  addr, mem_dout, mem_rd, mem_wr, ir_out, z_out, r0_out, bus_err
    );

    modport slave (
        input  read, write, arload, arinc, pcinc, pcload,
        input  drload, trload, irload, r1load, r0load, xload, zload,
        input  pcbus, drhbus, drlbus, trbus, r1bus, r0bus, membus, busmem,
        input  alus, mem_din,
        output addr, mem_dout, mem_rd, mem_wr, ir_out, z_out, r0_out, bus_err
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU: A=X, B=bus low byte, carry discarded.
// Latency: 0 cycles (pure logic). Backpressure: none.
// Ports: a_i, b_i operands; alus_i op code; result_o; zero_o = (result_o == 0).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    alus_i,
    output logic [DW-1:0] result_o,
    output logic          zero_o
);

    // Unknown or reserved op codes fall through to default, so an X on
    // alus_i yields 0 rather than an X result.
    always_comb begin
        result_o = '0;
        case (alus_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_INC:  result_o = a_i + DW'(1);
            ALU_DEC:  result_o = a_i - DW'(1);
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_NOT:  result_o = ~a_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SHL:  result_o = {a_i[DW-2:0], 1'b0};
            ALU_PASS: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu_datapath.sv
// Register/bus datapath of the teaching CPU: PC, AR, DR, TR, IR, R0, R1, X, Z, shared bus, ALU.
// Latency: every strobe takes effect at the next rising edge; memory read is same-cycle via membus.
// Backpressure: none; bus contention (or read+write together) sets the sticky bus_err flag.
// Ports: clk, rst (async active-low), dp (slave side of cpu_datapath_if).
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    cpu_datapath_if.slave  dp
);

    logic [AW-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DW-1:0] dr_q, dr_d, tr_q, tr_d, ir_q, ir_d;
    logic [DW-1:0] r0_q, r0_d, r1_q, r1_d, x_q, x_d;
    logic          z_q, z_d, err_q, err_d;

    logic [AW-1:0] bus;
    logic [2:0]    src_cnt;
    logic          multi_src;
    logic [DW-1:0] alu_res;
    logic          alu_zero;

    // Wired-OR bus: every enabled source contributes, none enabled gives 0.
    always_comb begin
        bus = '0;
        if (dp.pcbus)  bus = bus | pc_q;
        if (dp.drhbus) bus = bus | {dr_q, {DW{1'b0}}};
        if (dp.drlbus) bus = bus | zext(dr_q);
        if (dp.trbus)  bus = bus | zext(tr_q);
        if (dp.r1bus)  bus = bus | zext(r1_q);
        if (dp.r0bus)  bus = bus | zext(r0_q);
        if (dp.membus) bus = bus | zext(dp.mem_din);
    end

    assign src_cnt = 3'(dp.pcbus) + 3'(dp.drhbus) + 3'(dp.drlbus) + 3'(dp.trbus)
                   + 3'(dp.r1bus) + 3'(dp.r0bus) + 3'(dp.membus);

    // DR high + TR low is the one intentional two-source case: it builds {DR,TR}.
    assign multi_src = (src_cnt > 3'd1) &&
                       !((src_cnt == 3'd2) && dp.drhbus && dp.trbus);

    cpu_alu u_alu (
        .a_i      (x_q),
        .b_i      (bus[DW-1:0]),
        .alus_i   (dp.alus),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // Next state; TR and IR take the pre-edge DR so drload+trload shifts DR->TR.
    always_comb begin
        ar_d  = dp.arload ? bus : (dp.arinc ? ar_q + AW'(1) : ar_q);
        pc_d  = dp.pcload ? bus : (dp.pcinc ? pc_q + AW'(1) : pc_q);
        dr_d  = dp.drload ? bus[DW-1:0] : dr_q;
        tr_d  = dp.trload ? dr_q : tr_q;
        ir_d  = dp.irload ? dr_q : ir_q;
        x_d   = dp.xload  ? bus[DW-1:0] : x_q;
        r1_d  = dp.r1load ? bus[DW-1:0] : r1_q;
        r0_d  = dp.r0load ? alu_res : r0_q;
        z_d   = dp.zload  ? alu_zero : z_q;
        err_d = err_q | multi_src | (dp.read & dp.write);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            ar_q  <= '0;
            dr_q  <= '0;
            tr_q  <= '0;
            ir_q  <= '0;
            x_q   <= '0;
            r1_q  <= '0;
            r0_q  <= '0;
            z_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ar_q  <= ar_d;
            dr_q  <= dr_d;
            tr_q  <= tr_d;
            ir_q  <= ir_d;
            x_q   <= x_d;
            r1_q  <= r1_d;
            r0_q  <= r0_d;
            z_q   <= z_d;
            err_q <= err_d;
        end
    end

    assign dp.addr     = ar_q;
    assign dp.mem_dout = dp.busmem ? bus[DW-1:0] : '0;
    assign dp.mem_rd   = dp.read;
    // A simultaneous read blocks the write so memory is never corrupted by a conflict.
    assign dp.mem_wr   = dp.write & ~dp.read;
    assign dp.ir_out   = ir_q;
    assign dp.z_out    = z_q;
    assign dp.r0_out   = r0_q;
    assign dp.bus_err  = err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized control words
// checked against a behavioural register-level model.
// Latency: n/a. Backpressure: n/a.
module tb_cpu_datapath;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_datapath_if dp();
    cpu_datapath u_dut (.clk(clk), .rst(rst), .dp(dp.slave));

    // asynchronous-read memory seen by the datapath
    logic [7:0] mem [0:65535];
    assign dp.mem_din = mem[dp.addr];

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [15:0] m_pc, m_ar;
    logic [7:0]  m_dr, m_tr, m_ir, m_r0, m_r1, m_x;
    logic        m_z, m_err;

    function automatic logic [15:0] model_bus();
        logic [15:0] b;
        b = 16'h0000;
        if (dp.pcbus)  b = b | m_pc;
        if (dp.drhbus) b = b | (16'(m_dr) * 16'd256);
        if (dp.trbus)  b = b | 16'(m_tr);
        if (dp.drlbus) b = b | 16'(m_dr);
        if (dp.r1bus)  b = b | 16'(m_r1);
        if (dp.r0bus)  b = b | 16'(m_r0);
        if (dp.membus) b = b | 16'(mem[m_ar]);
        return b;
    endfunction

    function automatic logic [7:0] model_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            4'd1:    r = int'(a) + int'(b);
            4'd2:    r = int'(a) - int'(b) + 256;
            4'd3:    r = int'(a) + 1;
            4'd4:    r = int'(a) + 255;
            4'd5:    r = int'(a & b);
            4'd6:    r = int'(a | b);
            4'd7:    r = 255 - int'(a);
            4'd8:    r = int'(a ^ b);
            4'd9:    r = int'(a) * 2;
            4'd10:   r = int'(b);
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    function automatic logic model_conflict();
        int n;
        n = $countones({dp.pcbus, dp.drhbus, dp.drlbus, dp.trbus, dp.r1bus, dp.r0bus, dp.membus});
        return ((n > 1) && !(n == 2 && dp.drhbus && dp.trbus)) || (dp.read && dp.write);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ar = 0; m_dr = 0; m_tr = 0; m_ir = 0;
        m_r0 = 0; m_r1 = 0; m_x = 0; m_z = 0; m_err = 0;
    endtask

    task automatic idle();
        {dp.read, dp.write, dp.arload, dp.arinc, dp.pcinc, dp.pcload} = '0;
        {dp.drload, dp.trload, dp.irload, dp.r1load, dp.r0load, dp.xload, dp.zload} = '0;
        {dp.pcbus, dp.drhbus, dp.drlbus, dp.trbus, dp.r1bus, dp.r0bus, dp.membus, dp.busmem} = '0;
        dp.alus = 4'b0000;
    endtask

    // Put v at the current address and route it onto the bus for this cycle.
    task automatic mem_src(input logic [7:0] v);
        mem[m_ar] = v;
        dp.read = 1'b1;
        dp.membus = 1'b1;
    endtask

    // One clock: model computes from pre-edge state, returns at the next falling edge.
    task automatic tick();
        logic [15:0] b, n_pc, n_ar;
        logic [7:0]  res;
        logic        conf, wr;
        logic [15:0] wa;
        logic [7:0]  wd;
        b    = model_bus();
        res  = model_alu(dp.alus, m_x, b[7:0]);
        conf = model_conflict();
        wr = dp.mem_wr; wa = dp.addr; wd = dp.mem_dout;
        n_ar = dp.arload ? b : (dp.arinc ? m_ar + 16'd1 : m_ar);
        n_pc = dp.pcload ? b : (dp.pcinc ? m_pc + 16'd1 : m_pc);
        @(posedge clk);
        #1;
        if (dp.trload) m_tr = m_dr;
        if (dp.irload) m_ir = m_dr;
        if (dp.drload) m_dr = b[7:0];
        if (dp.xload)  m_x  = b[7:0];
        if (dp.r1load) m_r1 = b[7:0];
        if (dp.r0load) m_r0 = res;
        if (dp.zload)  m_z  = (res == 8'h00);
        m_err = m_err | conf;
        m_ar = n_ar;
        m_pc = n_pc;
        if (wr) mem[wa] = wd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        #2 rst = 1'b0;
        #10;
        model_reset();
        tests_run++;
        if ({dp.addr, dp.ir_out, dp.r0_out, dp.z_out, dp.bus_err, dp.mem_rd, dp.mem_wr} !== 37'h0) begin
            tests_failed++;
            $display("FAIL reset_state: addr=%h ir=%h r0=%h z=%b err=%b rd=%b wr=%b, want all 0",
                     dp.addr, dp.ir_out, dp.r0_out, dp.z_out, dp.bus_err, dp.mem_rd, dp.mem_wr);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        do_reset();
        mem[0] = 8'h10;
        dp.pcbus = 1; dp.arload = 1; tick(); idle();
        dp.read = 1; dp.membus = 1; dp.drload = 1; dp.pcinc = 1; tick(); idle();
        dp.pcbus = 1; dp.arload = 1; dp.irload = 1; tick(); idle();
        tests_run++;
        if (dp.ir_out !== 8'h10) begin tests_failed++; $display("FAIL fetch_ir: got %h want 10", dp.ir_out); end
        tests_run++;
        if (dp.addr !== 16'h0001) begin tests_failed++; $display("FAIL fetch_pc_ar: got %h want 0001", dp.addr); end
    endtask

    task automatic test_alu();
        do_reset();
        mem_src(8'hF0); dp.drload = 1; tick(); idle();
        dp.drlbus = 1; dp.xload = 1; tick(); idle();
        mem_src(8'h10); dp.r1load = 1; tick(); idle();
        dp.r1bus = 1; dp.r0load = 1; dp.zload = 1; dp.alus = ALU_ADD; tick(); idle();
        tests_run++;
        if ({dp.r0_out, dp.z_out} !== {8'h00, 1'b1}) begin
            tests_failed++; $display("FAIL add_wrap: r0=%h z=%b want 00 1", dp.r0_out, dp.z_out);
        end
        mem_src(8'h05); dp.xload = 1; tick(); idle();
        mem_src(8'h03); dp.r1load = 1; tick(); idle();
        dp.r1bus = 1; dp.r0load = 1; dp.zload = 1; dp.alus = ALU_SUB; tick(); idle();
        tests_run++;
        if ({dp.r0_out, dp.z_out} !== {8'h02, 1'b0}) begin
            tests_failed++; $display("FAIL sub: r0=%h z=%b want 02 0", dp.r0_out, dp.z_out);
        end
        dp.r0load = 1; dp.alus = ALU_SHL; tick(); idle();
        tests_run++;
        if (dp.r0_out !== 8'h0A) begin tests_failed++; $display("FAIL shl: r0=%h want 0a", dp.r0_out); end
        dp.r1bus = 1; dp.r0load = 1; dp.alus = 4'b1100; tick(); idle();
        tests_run++;
        if (dp.r0_out !== 8'h00) begin tests_failed++; $display("FAIL reserved_op: r0=%h want 00", dp.r0_out); end
        dp.r0load = 1; dp.alus = ALU_NOT; tick(); idle();
        dp.r1bus = 1; dp.r0load = 1; dp.zload = 1; dp.alus = 4'bxxxx; tick(); idle();
        tests_run++;
        if ({dp.r0_out, dp.z_out} !== {8'h00, 1'b1}) begin
            tests_failed++; $display("FAIL alus_x: r0=%h z=%b want 00 1", dp.r0_out, dp.z_out);
        end
    endtask

    task automatic test_jump();
        do_reset();
        mem_src(8'h34); dp.drload = 1; tick(); idle();
        mem_src(8'h12); dp.drload = 1; dp.trload = 1; tick(); idle();
        dp.drhbus = 1; dp.trbus = 1; dp.pcload = 1; dp.irload = 1; tick(); idle();
        dp.pcbus = 1; dp.arload = 1; tick(); idle();
        tests_run++;
        if (dp.addr !== 16'h1234) begin tests_failed++; $display("FAIL jump_pc: got %h want 1234", dp.addr); end
        tests_run++;
        if (dp.ir_out !== 8'h12) begin tests_failed++; $display("FAIL jump_dr_shift: ir=%h want 12", dp.ir_out); end
        tests_run++;
        if (dp.bus_err !== 1'b0) begin tests_failed++; $display("FAIL jump_no_err: got %b want 0", dp.bus_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_src(8'hFF); dp.drload = 1; tick(); idle();
        mem_src(8'hFF); dp.drload = 1; dp.trload = 1; tick(); idle();
        dp.drhbus = 1; dp.trbus = 1; dp.arload = 1; tick(); idle();
        tests_run++;
        if (dp.addr !== 16'hFFFF) begin tests_failed++; $display("FAIL ar_load_ffff: got %h want ffff", dp.addr); end
        dp.arinc = 1; tick(); idle();
        tests_run++;
        if (dp.addr !== 16'h0000) begin tests_failed++; $display("FAIL ar_wrap: got %h want 0000", dp.addr); end
        mem_src(8'h42); dp.arload = 1; dp.arinc = 1; tick(); idle();
        tests_run++;
        if (dp.addr !== 16'h0042) begin tests_failed++; $display("FAIL ar_prio: got %h want 0042", dp.addr); end
        mem_src(8'h77); dp.pcload = 1; dp.pcinc = 1; tick(); idle();
        dp.pcbus = 1; dp.arload = 1; tick(); idle();
        tests_run++;
        if (dp.addr !== 16'h0077) begin tests_failed++; $display("FAIL pc_prio: got %h want 0077", dp.addr); end
    endtask

    task automatic test_conflict();
        do_reset();
        dp.r0bus = 1; dp.r1bus = 1; tick(); idle();
        tests_run++;
        if (dp.bus_err !== 1'b1) begin tests_failed++; $display("FAIL conflict_set: got %b want 1", dp.bus_err); end
        repeat (10) tick();
        tests_run++;
        if (dp.bus_err !== 1'b1) begin tests_failed++; $display("FAIL conflict_sticky: got %b want 1", dp.bus_err); end
        do_reset();
        tests_run++;
        if (dp.bus_err !== 1'b0) begin tests_failed++; $display("FAIL conflict_clear: got %b want 0", dp.bus_err); end
        dp.read = 1; dp.write = 1; dp.busmem = 1;
        #1;
        tests_run++;
        if ({dp.mem_rd, dp.mem_wr} !== 2'b10) begin
            tests_failed++; $display("FAIL rw_suppress: rd/wr=%b%b want 10", dp.mem_rd, dp.mem_wr);
        end
        tick(); idle();
        tests_run++;
        if (dp.bus_err !== 1'b1) begin tests_failed++; $display("FAIL rw_err: got %b want 1", dp.bus_err); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        dp.alus = ALU_CLR; dp.zload = 1; tick(); idle();
        mem_src(8'h55); dp.alus = ALU_PASS; dp.r0load = 1; dp.arload = 1; tick(); idle();
        tests_run++;
        if ({dp.r0_out, dp.z_out, dp.addr} !== {8'h55, 1'b1, 16'h0055}) begin
            tests_failed++; $display("FAIL midop_setup: r0=%h z=%b addr=%h want 55 1 0055", dp.r0_out, dp.z_out, dp.addr);
        end
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if ({dp.r0_out, dp.z_out, dp.addr, dp.ir_out} !== 33'h0) begin
            tests_failed++; $display("FAIL midop_reset: r0=%h z=%b addr=%h ir=%h want 0", dp.r0_out, dp.z_out, dp.addr, dp.ir_out);
        end
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] b;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            idle();
            case ($urandom_range(0, 8))
                1: dp.pcbus = 1;
                2: dp.drhbus = 1;
                3: dp.drlbus = 1;
                4: dp.trbus = 1;
                5: dp.r1bus = 1;
                6: dp.r0bus = 1;
                7: begin dp.membus = 1; dp.read = 1; end
                8: begin dp.drhbus = 1; dp.trbus = 1; end
                default: ;
            endcase
            if ($urandom_range(0, 79) == 0) begin dp.r0bus = 1; dp.r1bus = 1; end
            dp.arload = ($urandom_range(0, 5) == 0);
            dp.arinc  = ($urandom_range(0, 2) == 0);
            dp.pcload = ($urandom_range(0, 5) == 0);
            dp.pcinc  = ($urandom_range(0, 2) == 0);
            dp.drload = ($urandom_range(0, 2) == 0);
            dp.trload = ($urandom_range(0, 3) == 0);
            dp.irload = ($urandom_range(0, 3) == 0);
            dp.xload  = ($urandom_range(0, 3) == 0);
            dp.r1load = ($urandom_range(0, 3) == 0);
            dp.r0load = ($urandom_range(0, 2) == 0);
            dp.zload  = ($urandom_range(0, 2) == 0);
            dp.busmem = ($urandom_range(0, 1) == 0);
            dp.write  = !dp.read && ($urandom_range(0, 5) == 0);
            dp.alus   = 4'($urandom_range(0, 15));
            #1;
            b = model_bus();
            tests_run++;
            if ({dp.mem_dout, dp.mem_wr, dp.mem_rd} !== {(dp.busmem ? b[7:0] : 8'h00), dp.write, dp.read}) begin
                tests_failed++;
                $display("FAIL rand_mem[%0d]: dout=%h wr=%b rd=%b want %h %b %b", i, dp.mem_dout, dp.mem_wr, dp.mem_rd,
                         (dp.busmem ? b[7:0] : 8'h00), dp.write, dp.read);
            end
            tick();
            tests_run++;
            if ({dp.addr, dp.ir_out, dp.r0_out, dp.z_out, dp.bus_err} !== {m_ar, m_ir, m_r0, m_z, m_err}) begin
                tests_failed++;
                $display("FAIL rand_regs[%0d]: ar=%h ir=%h r0=%h z=%b err=%b want %h %h %h %b %b", i,
                         dp.addr, dp.ir_out, dp.r0_out, dp.z_out, dp.bus_err, m_ar, m_ir, m_r0, m_z, m_err);
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        model_reset();
        test_reset();
        test_fetch();
        test_alu();
        test_jump();
        test_wrap();
        test_conflict();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
